// File: rtl/layer_hit_injector.sv
// -----------------------------------------------------------------------------
// layer_hit_injector
//
// Synthetic-hit source for chamber self-test. Generates straight-track
// wire-group hit bursts on six 96-bit layer buses, in the same format the
// one-shot input stage receives. It is muxed with the real AFEB inputs. Each
// burst is a train of fixed-width pulses, and a dead gap between pulses lets
// the one-shots re-arm.
//
// Parameters
//   GAP_CYCLES  idle cycles between pulses (>= 2)
//
// Ports
//   i_clk       system clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   i_start     single-cycle request, sampled only in IDLE
//   i_abort     return to IDLE on the next edge, no done pulse
//   i_key_wg    wire group to hit (0..95), captured at start
//   i_ly_mask   layer enable, bit n drives o_lyn, captured at start
//   i_delay     cycles from start to first pulse, captured at start
//   i_width     pulse width minus one, captured at start
//   i_repeat    number of pulses minus one, captured at start
//   o_ly0..5    registered hit patterns
//   o_busy      high from the cycle after an accepted start until IDLE
//   o_done      one-cycle pulse on normal completion
//
// Build option
//   INJ_SWEEP_EN  when defined, the wire group advances by one (95 wraps to 0)
//                 after each pulse's gap. A captured key above 95 is forced
//                 to 0 first.
// -----------------------------------------------------------------------------
module layer_hit_injector #(
    parameter int unsigned GAP_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic [6:0]  i_key_wg,
    input  logic [5:0]  i_ly_mask,
    input  logic [3:0]  i_delay,
    input  logic [2:0]  i_width,
    input  logic [7:0]  i_repeat,
    output logic [95:0] o_ly0,
    output logic [95:0] o_ly1,
    output logic [95:0] o_ly2,
    output logic [95:0] o_ly3,
    output logic [95:0] o_ly4,
    output logic [95:0] o_ly5,
    output logic        o_busy,
    output logic        o_done
);

    localparam int unsigned GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_DRIVE,
        ST_GAP
    } state_t;

    state_t           r_state;
    logic [3:0]       r_dly_cnt;
    logic [2:0]       r_wid_cnt;
    logic [7:0]       r_rep_cnt;
    logic [GW-1:0]    r_gap_cnt;
    logic [2:0]       r_width;
    logic [5:0]       r_mask;
    logic [6:0]       r_wg;
    logic [5:0][95:0] r_ly;
    logic             r_busy;
    logic             r_done;

    logic [95:0]      w_onehot;
    logic [5:0][95:0] w_pat;

    // Compare-based decode. A wire group above 95 matches no bit, so an
    // illegal key simply yields an all-zero pattern without indexing.
    always_comb begin
        w_onehot = '0;
        for (int unsigned b = 0; b < 96; b++) begin
            w_onehot[b] = (r_wg == 7'(b));
        end
    end

    always_comb begin
        w_pat = '0;
        for (int unsigned n = 0; n < 6; n++) begin
            w_pat[n] = r_mask[n] ? w_onehot : '0;
        end
    end

    // The layer registers follow the state with one cycle of lag. As a result,
    // the first pulse appears after edge E(2+delay), and each pulse lasts
    // exactly as many cycles as the FSM spends in DRIVE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_dly_cnt <= '0;
            r_wid_cnt <= '0;
            r_rep_cnt <= '0;
            r_gap_cnt <= '0;
            r_width   <= '0;
            r_mask    <= '0;
            r_wg      <= '0;
            r_ly      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else if (i_abort) begin
            r_state <= ST_IDLE;
            r_ly    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_ly   <= (r_state == ST_DRIVE) ? w_pat : '0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_dly_cnt <= i_delay;
                        r_wid_cnt <= i_width;
                        r_rep_cnt <= i_repeat;
                        r_width   <= i_width;
                        r_mask    <= i_ly_mask;
`ifdef INJ_SWEEP_EN
                        r_wg      <= (i_key_wg > 7'd95) ? '0 : i_key_wg;
`else
                        r_wg      <= i_key_wg;
`endif
                        r_busy    <= 1'b1;
                        r_state   <= ST_DELAY;
                    end
                end
                ST_DELAY: begin
                    if (r_dly_cnt == '0) begin
                        r_state <= ST_DRIVE;
                    end else begin
                        r_dly_cnt <= r_dly_cnt - 4'd1;
                    end
                end
                ST_DRIVE: begin
                    if (r_wid_cnt == '0) begin
                        r_gap_cnt <= GW'(GAP_CYCLES - 1);
                        r_state   <= ST_GAP;
                    end else begin
                        r_wid_cnt <= r_wid_cnt - 3'd1;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == '0) begin
                        if (r_rep_cnt == '0) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_rep_cnt <= r_rep_cnt - 8'd1;
                            r_wid_cnt <= r_width;
`ifdef INJ_SWEEP_EN
                            r_wg      <= (r_wg == 7'd95) ? '0 : r_wg + 7'd1;
`endif
                            r_state   <= ST_DRIVE;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_ly0  = r_ly[0];
    assign o_ly1  = r_ly[1];
    assign o_ly2  = r_ly[2];
    assign o_ly3  = r_ly[3];
    assign o_ly4  = r_ly[4];
    assign o_ly5  = r_ly[5];
    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule

// File: tb/tb_layer_hit_injector.sv
module tb_layer_hit_injector;

    localparam int G = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        i_start = 1'b0;
    logic        i_abort = 1'b0;
    logic [6:0]  i_key_wg = '0;
    logic [5:0]  i_ly_mask = '0;
    logic [3:0]  i_delay = '0;
    logic [2:0]  i_width = '0;
    logic [7:0]  i_repeat = '0;
    logic [95:0] o_ly0, o_ly1, o_ly2, o_ly3, o_ly4, o_ly5;
    logic        o_busy, o_done;

    always #5 clk = ~clk;

    layer_hit_injector #(.GAP_CYCLES(G)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_abort(i_abort),
        .i_key_wg(i_key_wg), .i_ly_mask(i_ly_mask), .i_delay(i_delay),
        .i_width(i_width), .i_repeat(i_repeat),
        .o_ly0(o_ly0), .o_ly1(o_ly1), .o_ly2(o_ly2), .o_ly3(o_ly3),
        .o_ly4(o_ly4), .o_ly5(o_ly5), .o_busy(o_busy), .o_done(o_done)
    );

    typedef struct {
        int s;       // cycle index of the first sample after the start edge
        int key;
        int mask;
        int dly;
        int w;
        int rep;
        int kill_k;  // sample at which abort/reset kills the burst, -1 if none
    } burst_t;

    burst_t sb[$];
    int     errors = 0;
    int     checks = 0;
    int     cyc = 0;
    bit     mon_active = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int burst_len(input burst_t b);
        return 1 + b.dly + (b.rep + 1) * (b.w + 1 + G);
    endfunction

    // Expected {ly5..ly0} at sample k of a burst.
    function automatic logic [575:0] exp_ly(input burst_t b, input int k);
        logic [575:0] r;
        int period, j, p, wg;
        r = '0;
        period = b.w + 1 + G;
        j = k - 2 - b.dly;
        if (j < 0) return r;
        p = j / period;
        if (p > b.rep) return r;
        if (j % period > b.w) return r;
`ifdef INJ_SWEEP_EN
        wg = ((b.key > 95) ? 0 : b.key) + p;
        wg = wg % 96;
`else
        wg = b.key;
`endif
        if (wg > 95) return r;
        for (int n = 0; n < 6; n++)
            if (((b.mask >> n) & 1) == 1) r[n*96 + wg] = 1'b1;
        return r;
    endfunction

    // Monitor: pops a burst descriptor when busy rises and checks each cycle.
    initial begin
        burst_t       cur;
        int           k;
        int           len;
        logic [575:0] got;
        logic [575:0] e_ly;
        logic         e_busy, e_done;
        logic         prev_busy;
        prev_busy = 1'b0;
        k = 0;
        len = 0;
        forever begin
            @(negedge clk);
            got = {o_ly5, o_ly4, o_ly3, o_ly2, o_ly1, o_ly0};
            if (!mon_active) begin
                if (o_busy && !prev_busy) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_start cyc=%0d busy rose with no request pending", cyc);
                    end else begin
                        cur = sb.pop_front();
                        mon_active = 1;
                        len = burst_len(cur);
                        if (cyc != cur.s) begin
                            errors++;
                            $display("FAIL start_cycle got=%0d exp=%0d", cyc, cur.s);
                        end
                        k = 0;
                    end
                end else begin
                    checks++;
                    if (got != '0 || o_done !== 1'b0 || o_busy !== 1'b0) begin
                        errors++;
                        $display("FAIL idle cyc=%0d got ly=%h busy=%b done=%b exp all zero",
                                 cyc, got, o_busy, o_done);
                    end
                end
            end
            if (mon_active) begin
                if (cur.kill_k >= 0 && k >= cur.kill_k) begin
                    e_ly = '0; e_busy = 1'b0; e_done = 1'b0; mon_active = 0;
                end else if (k == len) begin
                    e_ly = '0; e_busy = 1'b0; e_done = 1'b1; mon_active = 0;
                end else begin
                    e_ly = exp_ly(cur, k); e_busy = 1'b1; e_done = 1'b0;
                end
                checks++;
                if (got !== e_ly || o_busy !== e_busy || o_done !== e_done) begin
                    errors++;
                    $display("FAIL trace key=%0d k=%0d got ly=%h busy=%b done=%b exp ly=%h busy=%b done=%b",
                             cur.key, k, got, o_busy, o_done, e_ly, e_busy, e_done);
                end
                k++;
            end
            prev_busy = o_busy;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic issue(input int key, input int mask, input int dly, input int w,
                         input int rep, input int kill_k, output burst_t b);
        b.key = key; b.mask = mask; b.dly = dly; b.w = w; b.rep = rep;
        b.kill_k = kill_k;
        b.s = cyc + 1;
        i_key_wg = 7'(key); i_ly_mask = 6'(mask); i_delay = 4'(dly);
        i_width = 3'(w); i_repeat = 8'(rep);
        i_start = 1'b1;
        sb.push_back(b);
        tick();
        i_start = 1'b0;
        // Scramble config inputs so a missing capture shows up.
        i_key_wg = 7'($urandom); i_ly_mask = 6'($urandom); i_delay = 4'($urandom);
        i_width = 3'($urandom); i_repeat = 8'($urandom);
    endtask

    task automatic run(input int key, input int mask, input int dly, input int w, input int rep);
        burst_t b;
        issue(key, mask, dly, w, rep, -1, b);
        wait_until(b.s + burst_len(b) + 1);
        tick();
    endtask

    initial begin
        burst_t a, b;
        int key, mask, dly, w, rep;
        #1 rst_n = 1'b0;
        repeat (4) tick();
        rst_n = 1'b1;
        tick();

        run(37, 6'b111111, 0, 0, 0);
        run(95, 6'b010101, 5, 3, 2);
        run(100, 6'b111111, 2, 1, 1);
        run(12, 0, 1, 2, 1);

        // Abort in the second DRIVE cycle.
        issue(20, 6'b111111, 1, 2, 1, 4, a);
        wait_until(a.s + 3);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        repeat (3) tick();

        // Start and abort together in IDLE: abort wins.
        i_start = 1'b1; i_abort = 1'b1;
        tick();
        i_start = 1'b0; i_abort = 1'b0;
        repeat (3) tick();

        // Start while busy is ignored.
        issue(50, 6'b111111, 0, 1, 1, -1, a);
        wait_until(a.s + 4);
        i_key_wg = 7'd10; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        wait_until(a.s + 25);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        wait_until(a.s + burst_len(a) + 1);
        tick();

        // Start accepted in the done cycle.
        issue(5, 6'b100001, 0, 0, 0, -1, a);
        wait_until(a.s + burst_len(a));
        issue(6, 6'b011110, 1, 1, 1, -1, b);
        wait_until(b.s + burst_len(b) + 1);
        tick();

        // Asynchronous reset while a pulse is on the outputs.
        issue(60, 6'b111111, 3, 3, 2, 5, a);
        wait_until(a.s + 5);
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        run(61, 6'b110011, 0, 2, 0);

        run(94, 6'b111111, 0, 1, 3);
        run(127, 6'b111111, 0, 0, 2);
        run(0, 6'b000001, 0, 0, 95);
        run(3, 6'b000010, 0, 0, 255);

        for (int i = 0; i < 24; i++) begin
            key  = ($urandom_range(0, 7) == 0) ? $urandom_range(96, 127) : $urandom_range(0, 95);
            mask = $urandom_range(0, 63);
            dly  = $urandom_range(0, 15);
            w    = $urandom_range(0, 7);
            rep  = $urandom_range(0, 4);
            issue(key, mask, dly, w, rep, -1, a);
            if ($urandom_range(0, 2) == 0) begin
                wait_until(a.s + burst_len(a));
            end else begin
                wait_until(a.s + burst_len(a) + 1);
                repeat ($urandom_range(0, 3)) tick();
            end
        end
        wait_until(cyc + 1);
        while (mon_active && cyc < 200000) tick();
        repeat (4) tick();

        checks++;
        if (sb.size() != 0 || mon_active) begin
            errors++;
            $display("FAIL leftover got pending=%0d active=%0d exp pending=0 active=0",
                     sb.size(), mon_active);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
